ace_ps2_keyboard: RTL and testbench
===================================

// Module: ace_ps2_keyboard
// PURPOSE
//   Keyboard-side responder for the Jupiter ACE 8x5 key matrix. Receives PS/2 set-2 scancodes,
//   keeps a registered 40-key pressed/released map, and answers the CPU row scan (filas =
//   A15..A8) with the active-low column code (columnas) that glue returns on IN from port FE.
//   Sits at top level next to the CPU/glue, in the clk_65 domain.
// PARAMETERS
//   TIMEOUT_CYCLES  65000  clk cycles with no PS/2 falling edge before a partial frame is dropped
// PORTS
//   clk        in   1  system clock (clk_65 domain)
//   reset      in   1  asynchronous, active-high reset
//   ps2_clk    in   1  raw PS/2 clock from the keyboard connector; asynchronous
//   ps2_data   in   1  raw PS/2 data from the keyboard connector; asynchronous
//   filas      in   8  row select = CPU A15..A8; bit r = 0 selects row r
//   columnas   out  5  column response; bit c = 0 means a key is pressed at (selected row, c)
//   frame_err  out  1  one-cycle pulse: a frame was rejected (parity, start, stop or timeout)
// BEHAVIOUR
//   Reset: columnas = 5'b11111 (all keys released), frame_err = 0, FSM in IDLE, both prefix
//     flags clear, timeout counter = 0. Asserting reset mid-frame discards the frame.
//   Input sync: ps2_clk and ps2_data each pass through 2 flops. A falling edge is sync'd
//     clk 1->0; on that cycle the sync'd data bit is sampled.
//   Frame FSM: IDLE -> DATA (when start bit = 0; start = 1 stays IDLE and pulses frame_err)
//     -> 8 bits LSB first -> PARITY -> STOP -> IDLE.
//     - Parity is odd: data bits plus the parity bit have an odd count of ones.
//     - Stop bit must be 1.
//     - A parity or stop failure drops the byte and pulses frame_err.
//   Timeout: outside IDLE, the counter increments each clk and clears on every falling edge.
//     When it reaches TIMEOUT_CYCLES: FSM -> IDLE, frame_err pulse, byte dropped.
//   Byte accept: one cycle after the stop-bit edge, the byte goes to the decoder (1-cycle latency).
//   Decoder:
//     - 0xF0 sets rel.
//     - 0xE0 sets ext.
//     - Any other byte clears rel and ext.
//     - With ext = 0, a mapped code sets that key's map bit when rel = 0 and clears it when
//       rel = 1. The map bit updates on the same cycle the byte is accepted.
//     - With ext = 1, the byte is ignored (no map change).
//     - Unmapped codes are ignored.
//     - The sequence E0 F0 xx sets both flags and then ignores xx.
//   Matrix map (row r = filas bit r; columns listed c0..c4):
//     r0: LShift(12) SymShift=RShift(59) Z(1A) X(22) C(21)
//     r1: A(1C) S(1B) D(23) F(2B) G(34)
//     r2: Q(15) W(1D) E(24) R(2D) T(2C)
//     r3: 1(16) 2(1E) 3(26) 4(25) 5(2E)
//     r4: 0(45) 9(46) 8(3E) 7(3D) 6(36)
//     r5: P(4D) O(44) I(43) U(3C) Y(35)
//     r6: Enter(5A) L(4B) K(42) J(3B) H(33)
//     r7: Space(29) M(3A) N(31) B(32) V(2A)
//   Column response: columnas[c] = ~OR over rows r with filas[r] = 0 of pressed[r][c].
//     The path from filas to columnas is purely combinational (zero latency), so the CPU IN
//     cycle sees it in the same access. With filas = 8'hFF, columnas = 5'b11111.
//   Multi-key: any number of keys may be held at once. Ghosting is not modelled.
//   Repeats: a typematic repeat of a held key re-sets an already-set bit (idempotent).
//     A release of a key that is not held is harmless.
// TESTING
//   1. Reset, then frame 0x1C (A), filas = 8'hFD -> columnas = 5'b11110; filas = 8'hFE -> 5'b11111.
//   2. Send F0 1C -> with filas = 8'hFD, columnas returns to 5'b11111 within 1 clk of the stop bit.
//   3. Hold 12 + 1A (Shift+Z), filas = 8'hFE -> columnas = 5'b11010.
//      filas = 8'h00 with 29 (Space) also held -> columnas = 5'b11010.
//   4. Frame 0x29 with a bad parity bit -> frame_err pulses once; filas = 8'h7F -> columnas = 5'b11111.
//   5. Send 4 bits of a frame, then idle for TIMEOUT_CYCLES -> frame_err pulse.
//      The next full frame 0x4D, filas = 8'hDF -> columnas = 5'b11110.
//   6. Send E0 5A, then E0 F0 5A -> map unchanged (filas = 8'hBF -> 5'b11111).
//      Assert reset with 16 (key 1) held -> columnas = 5'b11111 for every filas value.

Source files
------------

// File: rtl/ace_ps2_keyboard.sv
// ace_ps2_keyboard: PS/2 set-2 receiver driving the Jupiter ACE 8x5 key matrix answered to the CPU row scan.
module ace_ps2_keyboard #(
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [7:0] filas,
    output logic [4:0] columnas,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic          byte_vld_q, byte_vld_d;
    logic [7:0]    byte_q, byte_d;
    logic          rel_q, rel_d, ext_q, ext_d;
    logic [39:0]   map_q, map_d;
    logic          fall, din;
    logic [6:0]    key;

    // bit 6 = mapped, bits 5:0 = row*5 + column
    function automatic logic [6:0] lookup(input logic [7:0] code);
        case (code)
            8'h12: lookup = {1'b1, 6'd0};  8'h59: lookup = {1'b1, 6'd1};  8'h1A: lookup = {1'b1, 6'd2};
            8'h22: lookup = {1'b1, 6'd3};  8'h21: lookup = {1'b1, 6'd4};  8'h1C: lookup = {1'b1, 6'd5};
            8'h1B: lookup = {1'b1, 6'd6};  8'h23: lookup = {1'b1, 6'd7};  8'h2B: lookup = {1'b1, 6'd8};
            8'h34: lookup = {1'b1, 6'd9};  8'h15: lookup = {1'b1, 6'd10}; 8'h1D: lookup = {1'b1, 6'd11};
            8'h24: lookup = {1'b1, 6'd12}; 8'h2D: lookup = {1'b1, 6'd13}; 8'h2C: lookup = {1'b1, 6'd14};
            8'h16: lookup = {1'b1, 6'd15}; 8'h1E: lookup = {1'b1, 6'd16}; 8'h26: lookup = {1'b1, 6'd17};
            8'h25: lookup = {1'b1, 6'd18}; 8'h2E: lookup = {1'b1, 6'd19}; 8'h45: lookup = {1'b1, 6'd20};
            8'h46: lookup = {1'b1, 6'd21}; 8'h3E: lookup = {1'b1, 6'd22}; 8'h3D: lookup = {1'b1, 6'd23};
            8'h36: lookup = {1'b1, 6'd24}; 8'h4D: lookup = {1'b1, 6'd25}; 8'h44: lookup = {1'b1, 6'd26};
            8'h43: lookup = {1'b1, 6'd27}; 8'h3C: lookup = {1'b1, 6'd28}; 8'h35: lookup = {1'b1, 6'd29};
            8'h5A: lookup = {1'b1, 6'd30}; 8'h4B: lookup = {1'b1, 6'd31}; 8'h42: lookup = {1'b1, 6'd32};
            8'h3B: lookup = {1'b1, 6'd33}; 8'h33: lookup = {1'b1, 6'd34}; 8'h29: lookup = {1'b1, 6'd35};
            8'h3A: lookup = {1'b1, 6'd36}; 8'h31: lookup = {1'b1, 6'd37}; 8'h32: lookup = {1'b1, 6'd38};
            8'h2A: lookup = {1'b1, 6'd39};
            default: lookup = 7'd0;
        endcase
    endfunction

    assign fall      = clk_sync_q[2] & ~clk_sync_q[1];
    assign din       = dat_sync_q[1];
    assign key       = lookup(byte_q);
    assign frame_err = err_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_ok_d   = par_ok_q;
        tmo_d      = '0;
        err_d      = 1'b0;
        byte_vld_d = 1'b0;
        byte_d     = byte_q;
        rel_d      = rel_q;
        ext_d      = ext_q;
        map_d      = map_q;
        if (state_q != IDLE)
            tmo_d = fall ? '0 : tmo_q + 1'b1;
        if (fall) begin
            case (state_q)
                IDLE: begin
                    err_d     = din;
                    state_d   = din ? IDLE : DATA;
                    bit_cnt_d = '0;
                end
                DATA: begin
                    shift_d   = {din, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_q == 3'd7) ? PARITY : DATA;
                end
                PARITY: begin
                    par_ok_d = ^{shift_q, din};
                    state_d  = STOP;
                end
                default: begin
                    state_d    = IDLE;
                    byte_vld_d = din & par_ok_q;
                    byte_d     = shift_q;
                    err_d      = ~(din & par_ok_q);
                end
            endcase
        end else if (state_q != IDLE && tmo_d == TW'(TIMEOUT_CYCLES)) begin
            state_d = IDLE;
            err_d   = 1'b1;
            tmo_d   = '0;
        end
        // F0/E0 set their own flag and leave the other, so E0 F0 xx holds both
        if (byte_vld_q) begin
            rel_d = (byte_q == 8'hF0) ? 1'b1 : (byte_q == 8'hE0) ? rel_q : 1'b0;
            ext_d = (byte_q == 8'hE0) ? 1'b1 : (byte_q == 8'hF0) ? ext_q : 1'b0;
            if (key[6] && !ext_q)
                map_d[key[5:0]] = ~rel_q;
        end
    end

    always_comb begin
        columnas = '1;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 5; c++)
                if (!filas[r] && map_q[r*5+c])
                    columnas[c] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_ok_q   <= 1'b0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            rel_q      <= 1'b0;
            ext_q      <= 1'b0;
            map_q      <= '0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_ok_q   <= par_ok_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            byte_vld_q <= byte_vld_d;
            byte_q     <= byte_d;
            rel_q      <= rel_d;
            ext_q      <= ext_d;
            map_q      <= map_d;
        end
    end
endmodule

// File: tb/tb_ace_ps2_keyboard.sv
// tb_ace_ps2_keyboard: drives PS/2 frames and checks the matrix response through a column scoreboard.
module tb_ace_ps2_keyboard;
    localparam int TMO = 1000;

    typedef struct {
        string      tag;
        logic [7:0] f;
        logic [4:0] exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] filas = 8'hFF;
    logic [4:0] columnas;
    logic       frame_err;
    int         checks = 0;
    int         errors = 0;
    int         err_cnt = 0;
    int         e0;
    exp_t       sb[$];

    always #5 clk = ~clk;

    ace_ps2_keyboard #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .filas(filas), .columnas(columnas), .frame_err(frame_err)
    );

    always @(negedge clk) if (frame_err) err_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        clks(5);
        ps2_clk = 1'b0;
        clks(5);
        ps2_clk = 1'b1;
    endtask

    task automatic send(input logic [7:0] b, input logic bad = 1'b0);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad);
        ps2_bit(1'b1);
        clks(4);
    endtask

    task automatic expect_col(input string tag, input logic [7:0] f, input logic [4:0] e);
        sb.push_back('{tag, f, e});
    endtask

    task automatic drain();
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            filas = x.f;
            @(negedge clk);
            check(x.tag, {27'd0, columnas}, {27'd0, x.exp});
        end
        filas = 8'hFF;
    endtask

    initial begin
        clks(3);
        @(negedge clk) filas = 8'h00;
        @(negedge clk);
        check("reset_col", {27'd0, columnas}, 32'h1F);
        check("reset_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b0;
        clks(3);
        send(8'h1C);
        expect_col("a_row1", 8'hFD, 5'b11110);
        expect_col("a_row0", 8'hFE, 5'b11111);
        drain();
        send(8'hF0); send(8'h1C);
        expect_col("a_rel", 8'hFD, 5'b11111);
        drain();
        check("no_err_yet", err_cnt, 0);
        send(8'h12); send(8'h1A);
        expect_col("shift_z", 8'hFE, 5'b11010);
        expect_col("none_sel", 8'hFF, 5'b11111);
        drain();
        send(8'h29);
        expect_col("all_rows", 8'h00, 5'b11010);
        expect_col("space", 8'h7F, 5'b11110);
        drain();
        send(8'hF0); send(8'h29); send(8'hF0); send(8'h12); send(8'hF0); send(8'h1A);
        expect_col("all_rel", 8'h00, 5'b11111);
        drain();
        e0 = err_cnt;
        send(8'h29, 1'b1);
        check("parity_err", err_cnt - e0, 1);
        expect_col("parity_drop", 8'h7F, 5'b11111);
        drain();
        e0 = err_cnt;
        ps2_bit(1'b1);
        clks(4);
        check("start_err", err_cnt - e0, 1);
        e0 = err_cnt;
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        clks(TMO + 20);
        check("timeout_err", err_cnt - e0, 1);
        send(8'h4D);
        check("after_tmo_err", err_cnt - e0, 1);
        expect_col("p_key", 8'hDF, 5'b11110);
        drain();
        send(8'hE0); send(8'h5A);
        expect_col("ext_press", 8'hBF, 5'b11111);
        drain();
        send(8'hE0); send(8'hF0); send(8'h5A);
        expect_col("ext_rel", 8'hBF, 5'b11111);
        drain();
        send(8'h5A);
        expect_col("enter", 8'hBF, 5'b11110);
        drain();
        send(8'hF0); send(8'h5A); send(8'hF0); send(8'h22);
        expect_col("enter_rel", 8'hBF, 5'b11111);
        expect_col("stray_rel", 8'hFE, 5'b11111);
        drain();
        send(8'h16); send(8'h16);
        expect_col("key1_rep", 8'hF7, 5'b11110);
        drain();
        @(negedge clk) reset = 1'b1;
        clks(2);
        for (int f = 0; f < 256; f++) expect_col("reset_map", 8'(f), 5'b11111);
        drain();
        @(negedge clk) reset = 1'b0;
        clks(3);
        expect_col("post_reset", 8'h00, 5'b11111);
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
